mem_port_arbiter: RTL and testbench

- Shares the single-port 64x8 memory between two requesters, for example a program loader and an instruction fetch unit.
- Grants one memory access per cycle using round-robin priority.
- A requester can lock the port for a burst, bounded by a hold limit so the other requester cannot starve.
- Sits between the requesters and the memory. It drives the memory's address, write-enable and write-data inputs, and registers the memory's combinational read data back to the winner.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port memory, with bounded
// lock bursts and registered read-data return to each requester.
module mem_port_arbiter #(
  parameter int A        = 6,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_req,
  input  logic         r0_lock,
  input  logic         r0_we,
  input  logic [A-1:0] r0_addr,
  input  logic [W-1:0] r0_wdata,
  output logic         r0_gnt,
  output logic         r0_rvalid,
  output logic [W-1:0] r0_rdata,
  input  logic         r1_req,
  input  logic         r1_lock,
  input  logic         r1_we,
  input  logic [A-1:0] r1_addr,
  input  logic [W-1:0] r1_wdata,
  output logic         r1_gnt,
  output logic         r1_rvalid,
  output logic [W-1:0] r1_rdata,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_prio, w_prio_nxt;
  logic [HW-1:0]       r_hold, w_hold_nxt;
  logic [1:0]          r_rvalid;
  logic [1:0][W-1:0]   r_rdata;

  logic [1:0]          w_req, w_lock, w_we, w_gnt;
  logic [1:0][A-1:0]   w_addr;
  logic [1:0][W-1:0]   w_wdata;
  logic                w_any, w_win, w_forced, w_own_vld, w_own;

  assign w_req   = {r1_req, r0_req};
  assign w_lock  = {r1_lock, r0_lock};
  assign w_we    = {r1_we, r0_we};
  assign w_addr  = {r1_addr, r0_addr};
  assign w_wdata = {r1_wdata, r0_wdata};

  // Owner keeps the port unless it has held MAX_HOLD grants while the other waits.
  always_comb begin
    w_own_vld = (r_state != IDLE);
    w_own     = (r_state == LOCK1);
    w_forced  = 1'b0;
    w_win     = (w_req[0] & w_req[1]) ? r_prio : w_req[1];
    if (w_own_vld && w_req[w_own]) begin
      w_forced = (r_hold == HMAX) && w_req[~w_own];
      w_win    = w_own ^ w_forced;
    end
    w_any = rst_n & (|w_req);
  end

  assign w_gnt     = {w_any & w_win, w_any & ~w_win};
  assign r0_gnt    = w_gnt[0];
  assign r1_gnt    = w_gnt[1];
  assign mem_we    = w_any & w_we[w_win];
  assign mem_addr  = w_any ? w_addr[w_win]  : '0;
  assign mem_wdata = w_any ? w_wdata[w_win] : '0;

  always_comb begin
    w_state_nxt = IDLE;
    w_hold_nxt  = '0;
    w_prio_nxt  = r_prio;
    if (w_any) begin
      w_prio_nxt = ~w_win;
      if (w_lock[w_win]) begin
        w_state_nxt = w_win ? LOCK1 : LOCK0;
        if (w_own_vld && (w_own == w_win) && !w_forced)
          w_hold_nxt = (r_hold == HMAX) ? r_hold : r_hold + HW'(1);
        else
          w_hold_nxt = HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ret
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rvalid[i] <= 1'b0;
        r_rdata[i]  <= '0;
      end else begin
        r_rvalid[i] <= w_gnt[i] & ~w_we[i];
        if (w_gnt[i] & ~w_we[i]) r_rdata[i] <= mem_rdata;
      end
    end
  end

  assign r0_rvalid = r_rvalid[0];
  assign r0_rdata  = r_rdata[0];
  assign r1_rvalid = r_rvalid[1];
  assign r1_rdata  = r_rdata[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural reference checked every cycle
// plus literal expectations for the scenarios of interest.
module tb_mem_port_arbiter;
  localparam int A = 6, W = 8, MAX_HOLD = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic r0_req = 0, r0_lock = 0, r0_we = 0, r1_req = 0, r1_lock = 0, r1_we = 0;
  logic [A-1:0] r0_addr = '0, r1_addr = '0;
  logic [W-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_we;
  logic [W-1:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [A-1:0] mem_addr;

  int n_chk = 0, n_err = 0;

  mem_port_arbiter #(.A(A), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory the DUT drives, and an independent copy the reference updates.
  logic [W-1:0] mem [64];
  logic [W-1:0] mmem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: owner (-1 none), consecutive locked grants, tie-break side.
  int m_owner = -1, m_cnt = 0, m_prio = 0;
  logic [1:0] e_rv = '0;
  logic [W-1:0] e_rd [2] = '{8'h0, 8'h0};

  always @(negedge clk) begin
    int w;
    logic [1:0] rq, lk, we;
    logic [A-1:0] ad [2];
    logic [W-1:0] wd [2];
    rq = {r1_req, r0_req}; lk = {r1_lock, r0_lock}; we = {r1_we, r0_we};
    ad[0] = r0_addr; ad[1] = r1_addr; wd[0] = r0_wdata; wd[1] = r1_wdata;
    if (!rst_n) begin
      chk("rst r0_gnt", r0_gnt, 0);      chk("rst r1_gnt", r1_gnt, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst r0_rvalid", r0_rvalid, 0); chk("rst r1_rvalid", r1_rvalid, 0);
      chk("rst r0_rdata", r0_rdata, 0);   chk("rst r1_rdata", r1_rdata, 0);
      m_owner = -1; m_cnt = 0; m_prio = 0; e_rv = '0; e_rd[0] = '0; e_rd[1] = '0;
    end else begin
      chk("m r0_rvalid", r0_rvalid, e_rv[0]); chk("m r0_rdata", r0_rdata, e_rd[0]);
      chk("m r1_rvalid", r1_rvalid, e_rv[1]); chk("m r1_rdata", r1_rdata, e_rd[1]);
      if (m_owner >= 0 && rq[m_owner])
        w = (m_cnt == MAX_HOLD && rq[1-m_owner]) ? 1 - m_owner : m_owner;
      else if (rq == 2'b11) w = m_prio;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
      else w = -1;
      chk("m r0_gnt", r0_gnt, w == 0);
      chk("m r1_gnt", r1_gnt, w == 1);
      chk("m mem_we", mem_we, (w >= 0) ? we[w] : 1'b0);
      chk("m mem_addr", mem_addr, (w >= 0) ? ad[w] : '0);
      chk("m mem_wdata", mem_wdata, (w >= 0) ? wd[w] : '0);
      e_rv = '0;
      if (w >= 0) begin
        if (we[w]) mmem[ad[w]] = wd[w];
        else begin e_rv[w] = 1'b1; e_rd[w] = mmem[ad[w]]; end
        if (lk[w]) begin
          m_cnt = (m_owner == w) ? ((m_cnt < MAX_HOLD) ? m_cnt + 1 : MAX_HOLD) : 1;
          m_owner = w;
        end else begin m_owner = -1; m_cnt = 0; end
        m_prio = 1 - w;
      end else begin m_owner = -1; m_cnt = 0; end
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  task automatic drv(input logic q0, l0, w0, input int a0, d0,
                     input logic q1, l1, w1, input int a1, d1);
    r0_req = q0; r0_lock = l0; r0_we = w0; r0_addr = A'(a0); r0_wdata = W'(d0);
    r1_req = q1; r1_lock = l1; r1_we = w1; r1_addr = A'(a1); r1_wdata = W'(d1);
  endtask

  task automatic idle(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    nxt(); rst_n = 1'b0; idle(); smp();
    nxt(); rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = W'(i * 3 + 1); mmem[i] = W'(i * 3 + 1); end
    mem[5] = 8'h3C; mmem[5] = 8'h3C;
    smp(); smp();
    nxt(); rst_n = 1'b1;

    // single read by r0
    drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0); smp();
    chk("t1 r0_gnt", r0_gnt, 1); chk("t1 mem_addr", mem_addr, 5); chk("t1 r1_gnt", r1_gnt, 0);
    nxt(); idle(); smp();
    chk("t1 r0_rvalid", r0_rvalid, 1); chk("t1 r0_rdata", r0_rdata, 8'h3C);
    chk("t1 r1_rvalid", r1_rvalid, 0); chk("t1 r1_rdata", r1_rdata, 0);

    // round robin, no lock
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, 1, i + 1, 8'h10 + i, 1, 0, 0, 10, 0); smp();
      chk("t2 r0_gnt", r0_gnt, (i % 2) == 0); chk("t2 r1_gnt", r1_gnt, (i % 2) == 1);
      chk("t2 mem_we", mem_we, (i % 2) == 0);
      nxt();
    end

    // locked burst with forced release after MAX_HOLD grants
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv(1, 1, 1, i, 8'h80 + i, 1, 0, 0, 20, 0); smp();
      chk("t3 r0_gnt", r0_gnt, i != 8); chk("t3 r1_gnt", r1_gnt, i == 8);
      nxt();
    end

    // r1 lock with r0 idle never releases; then r0 takes over
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(0, 0, 0, 0, 0, 1, 1, 0, 30, 0); smp();
      chk("t4 r1_gnt", r1_gnt, 1); chk("t4 r0_gnt", r0_gnt, 0);
      nxt();
    end
    drv(1, 0, 0, 0, 0, 0, 1, 0, 30, 0); smp();
    chk("t4 r0 takeover", r0_gnt, 1); chk("t4 r1 lock no req", r1_gnt, 0);
    nxt(); idle(); smp();
    chk("t4 r0_rvalid", r0_rvalid, 1); chk("t4 r0_rdata", r0_rdata, 8'h80);

    // write/read collision on addr 63
    do_reset();
    drv(1, 0, 1, 63, 8'hA5, 1, 0, 0, 63, 0); smp();
    chk("t5 r0_gnt", r0_gnt, 1); chk("t5 r1_gnt", r1_gnt, 0); chk("t5 mem_we", mem_we, 1);
    nxt(); drv(0, 0, 0, 0, 0, 1, 0, 0, 63, 0); smp();
    chk("t5 r1_gnt", r1_gnt, 1); chk("t5 mem63", mem[63], 8'hA5);
    nxt(); idle(); smp();
    chk("t5 r1_rvalid", r1_rvalid, 1); chk("t5 r1_rdata", r1_rdata, 8'hA5);

    // reset in the middle of a lock
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 1, 40 + i, i, 0, 0, 0, 0, 0); smp();
      chk("t6 r0_gnt", r0_gnt, 1);
      nxt();
    end
    rst_n = 1'b0; drv(1, 1, 1, 44, 4, 1, 0, 0, 44, 0); smp();
    chk("t6 rst r0_gnt", r0_gnt, 0); chk("t6 rst mem_we", mem_we, 0);
    chk("t6 rst r1_gnt", r1_gnt, 0);
    nxt(); rst_n = 1'b1; drv(1, 1, 1, 50, 8'h55, 1, 0, 0, 50, 0); smp();
    chk("t6 post r0_gnt", r0_gnt, 1);
    nxt(); smp();
    chk("t6 post2 r0_gnt", r0_gnt, 1);
    nxt(); idle(); smp(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
